// File: rtl/overdrive_pkg.sv
// -----------------------------------------------------------------------------
// overdrive_pkg
// Shared types and defaults for the overdrive pipeline and its clipper.
//   od_mode_e    : clip mode selector (BYPASS, HARD, SOFT, reserved -> HARD)
//   DATA_W_DEF   : default sample width
//   GAIN_W_DEF   : default gain code width
//   SOFT_SHR_DEF : default soft-clip knee shift
//   PIPE_LAT     : cycles from input acceptance to out_valid
// -----------------------------------------------------------------------------
package overdrive_pkg;

  typedef enum logic [1:0] {
    OD_BYPASS = 2'd0,
    OD_HARD   = 2'd1,
    OD_SOFT   = 2'd2,
    OD_RSVD   = 2'd3
  } od_mode_e;

  localparam int DATA_W_DEF   = 16;
  localparam int GAIN_W_DEF   = 3;
  localparam int SOFT_SHR_DEF = 2;
  localparam int PIPE_LAT     = 3;

endpackage

// File: rtl/od_clipper.sv
// -----------------------------------------------------------------------------
// od_clipper
// Combinational third-stage clip function. Works on the magnitude of the
// full-precision product and reapplies the sign, so the result is always
// symmetric and never reaches negative full scale.
//   i_prod    : signed product, DATA_W+GAIN_W+1 bits
//   i_thr     : effective clip magnitude T (already limited to max positive)
//   i_mode    : clip mode; anything other than BYPASS/SOFT behaves as HARD
//   o_sample  : clipped/limited sample; only meaningful when o_clipped is set
//   o_clipped : product magnitude exceeded T and the result was altered
// -----------------------------------------------------------------------------
module od_clipper
  import overdrive_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int GAIN_W   = GAIN_W_DEF,
  parameter int SOFT_SHR = SOFT_SHR_DEF
) (
  input  logic [DATA_W+GAIN_W:0] i_prod,
  input  logic [DATA_W-1:0]      i_thr,
  input  od_mode_e               i_mode,
  output logic [DATA_W-1:0]      o_sample,
  output logic                   o_clipped
);

  localparam int P_W = DATA_W + GAIN_W + 1;
  localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [P_W-1:0]    MAX_EXT = {{(GAIN_W+1){1'b0}}, MAX_POS};

  logic              w_neg;
  logic [P_W-1:0]    w_mag;
  logic [P_W-1:0]    w_thr;
  logic [P_W-1:0]    w_excess;
  logic [P_W-1:0]    w_soft;
  logic [DATA_W-1:0] w_lim;

  // Magnitude of the product; the product range never includes the most
  // negative P_W-bit value, so the negation cannot overflow.
  assign w_neg    = i_prod[P_W-1];
  assign w_mag    = w_neg ? (~i_prod + P_W'(1)) : i_prod;
  assign w_thr    = {{(GAIN_W+1){1'b0}}, i_thr};
  assign w_excess = w_mag - w_thr;
  assign w_soft   = w_thr + (w_excess >> SOFT_SHR);

  // Pick the limited magnitude for the active mode, then restore the sign.
  // Soft knee output can exceed the sample range at high gain, so it is
  // saturated to the largest positive magnitude before the sign goes back on.
  always_comb begin
    o_clipped = (i_mode != OD_BYPASS) && (w_mag > w_thr);
    if (i_mode == OD_SOFT) begin
      w_lim = (w_soft > MAX_EXT) ? MAX_POS : w_soft[DATA_W-1:0];
    end else begin
      w_lim = i_thr;
    end
    o_sample = w_neg ? (~w_lim + DATA_W'(1)) : w_lim;
  end

endmodule

// File: rtl/overdrive_pipeline.sv
// -----------------------------------------------------------------------------
// overdrive_pipeline
// Three-stage overdrive for the pedal-board chain: register + gain ramp,
// full-precision multiply, then hard/soft clip or bypass. Valid/ready on
// both sides; a stall at the output freezes the whole pipe.
//   CLK, RESET_N             : clock, synchronous active-low reset
//   in_valid/in_ready        : input handshake
//   input_frame              : signed input sample
//   gain                     : target gain code (multiplier = gain_cur+1)
//   mode                     : od_mode_e encoding
//   threshold                : clip magnitude; MSB set means max positive
//   out_valid/out_ready      : output handshake
//   output_frame             : signed processed sample
//   clip_cnt                 : saturating count of clipped samples leaving
//                              the block (only with OVERDRIVE_CLIP_STATS_EN)
// Build option: define OVERDRIVE_CLIP_STATS_EN to add clip_cnt.
// -----------------------------------------------------------------------------
module overdrive_pipeline
  import overdrive_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int GAIN_W   = GAIN_W_DEF,
  parameter int SOFT_SHR = SOFT_SHR_DEF
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] input_frame,
  input  logic [GAIN_W-1:0] gain,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] threshold,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] output_frame
`ifdef OVERDRIVE_CLIP_STATS_EN
  ,
  output logic [15:0]       clip_cnt
`endif
);

  localparam int P_W = DATA_W + GAIN_W + 1;

  logic              w_stall;
  logic              w_accept;
  logic [GAIN_W-1:0] w_gainNext;
  logic [DATA_W-1:0] w_thrEff;
  logic [GAIN_W:0]   w_mult;
  logic [P_W-1:0]    w_dataExt;
  logic [P_W-1:0]    w_multExt;
  logic [P_W-1:0]    w_prod;
  logic [DATA_W-1:0] w_clipSample;
  logic              w_clipped;
  logic [DATA_W-1:0] w_s3Sample;

  logic [GAIN_W-1:0] r_gainCur;
  logic              r_s1Valid;
  logic [DATA_W-1:0] r_s1Data;
  od_mode_e          r_s1Mode;
  logic [DATA_W-1:0] r_s1Thr;
  logic [GAIN_W-1:0] r_s1Gain;
  logic              r_s2Valid;
  logic [P_W-1:0]    r_s2Prod;
  logic [DATA_W-1:0] r_s2Data;
  od_mode_e          r_s2Mode;
  logic [DATA_W-1:0] r_s2Thr;
  logic              r_s3Valid;
  logic [DATA_W-1:0] r_outFrame;
  logic              r_s3Clip;

  // Handshake: a held result at the output freezes every stage.
  assign w_stall  = r_s3Valid & ~out_ready;
  assign in_ready = RESET_N & ~w_stall;
  assign w_accept = in_valid & in_ready;

  // Gain slews one code per accepted sample toward the target.
  assign w_gainNext = (gain > r_gainCur) ? (r_gainCur + GAIN_W'(1)) :
                      (gain < r_gainCur) ? (r_gainCur - GAIN_W'(1)) :
                                           r_gainCur;

  assign w_thrEff = threshold[DATA_W-1] ? {1'b0, {(DATA_W-1){1'b1}}} : threshold;

  // Both operands are extended to the full product width so the low P_W
  // bits of the plain multiply are the exact signed product.
  assign w_mult    = {1'b0, r_s1Gain} + (GAIN_W+1)'(1);
  assign w_dataExt = {{(GAIN_W+1){r_s1Data[DATA_W-1]}}, r_s1Data};
  assign w_multExt = {{(DATA_W){1'b0}}, w_mult};
  assign w_prod    = w_dataExt * w_multExt;

  od_clipper #(
    .DATA_W  (DATA_W),
    .GAIN_W  (GAIN_W),
    .SOFT_SHR(SOFT_SHR)
  ) u_clipper (
    .i_prod   (r_s2Prod),
    .i_thr    (r_s2Thr),
    .i_mode   (r_s2Mode),
    .o_sample (w_clipSample),
    .o_clipped(w_clipped)
  );

  // Unclipped HARD/SOFT products already fit the sample width because
  // their magnitude is at most T; bypass passes the raw registered input.
  assign w_s3Sample = w_clipped              ? w_clipSample :
                      (r_s2Mode == OD_BYPASS) ? r_s2Data     :
                                                r_s2Prod[DATA_W-1:0];

  // Pipeline registers. Everything advances together when not stalled, so
  // the stage valids simply shift; reset drops all in-flight samples.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_gainCur  <= '0;
      r_s1Valid  <= 1'b0;
      r_s2Valid  <= 1'b0;
      r_s3Valid  <= 1'b0;
      r_outFrame <= '0;
      r_s3Clip   <= 1'b0;
    end else if (!w_stall) begin
      r_s1Valid <= w_accept;
      if (w_accept) begin
        r_s1Data  <= input_frame;
        r_s1Mode  <= od_mode_e'(mode);
        r_s1Thr   <= w_thrEff;
        r_gainCur <= w_gainNext;
        r_s1Gain  <= w_gainNext;
      end
      r_s2Valid <= r_s1Valid;
      r_s2Prod  <= w_prod;
      r_s2Data  <= r_s1Data;
      r_s2Mode  <= r_s1Mode;
      r_s2Thr   <= r_s1Thr;
      r_s3Valid <= r_s2Valid;
      if (r_s2Valid) begin
        r_outFrame <= w_s3Sample;
        r_s3Clip   <= w_clipped;
      end
    end
  end

  assign out_valid    = r_s3Valid;
  assign output_frame = r_outFrame;

`ifdef OVERDRIVE_CLIP_STATS_EN
  logic [15:0] r_clipCnt;

  // Count clipped results as they actually leave; hold at all-ones.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_clipCnt <= '0;
    end else if (r_s3Valid && out_ready && r_s3Clip && (r_clipCnt != 16'hFFFF)) begin
      r_clipCnt <= r_clipCnt + 16'd1;
    end
  end

  assign clip_cnt = r_clipCnt;
`else
  // Without the statistics option the clip flag only selects the output.
  logic w_unusedClip;
  assign w_unusedClip = r_s3Clip;
`endif

endmodule

// File: tb/tb_overdrive_pipeline.sv
// -----------------------------------------------------------------------------
// tb_overdrive_pipeline
// Self-checking bench for overdrive_pipeline (DATA_W=16, GAIN_W=3,
// SOFT_SHR=2). Expected samples are computed from a behavioural model when
// a sample is accepted and compared when the sample leaves the block.
// -----------------------------------------------------------------------------
module tb_overdrive_pipeline;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] input_frame;
  logic [2:0]  gain;
  logic [1:0]  mode;
  logic [15:0] threshold;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] output_frame;
`ifdef OVERDRIVE_CLIP_STATS_EN
  logic [15:0] clip_cnt;
`endif

  typedef struct {
    logic [15:0] data;
    int          acceptCycle;
    bit          clipped;
  } sbEntry_t;

  sbEntry_t sbQ[$];
  int errors = 0;
  int checks = 0;
  int cycle = 0;
  int modelGain = 0;
  int modelClips = 0;
  bit checkLat = 1'b0;

  overdrive_pipeline #(
    .DATA_W  (16),
    .GAIN_W  (3),
    .SOFT_SHR(2)
  ) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .input_frame (input_frame),
    .gain        (gain),
    .mode        (mode),
    .threshold   (threshold),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .output_frame(output_frame)
`ifdef OVERDRIVE_CLIP_STATS_EN
    ,
    .clip_cnt    (clip_cnt)
`endif
  );

  // 10 ns clock and a free-running cycle count for latency measurement.
  always #5 CLK = ~CLK;
  always @(posedge CLK) cycle <= cycle + 1;

  // Hard stop if the sequence ever hangs.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Reference behaviour of one sample given the gain used for it.
  function automatic logic [15:0] modelOut(input logic [15:0] x, input int g, input logic [1:0] m,
                                           input logic [15:0] thr, output bit clipped);
    int xs, t, p, mag, lim, r;
    clipped = 1'b0;
    xs = int'($signed(x));
    t = thr[15] ? 32767 : int'(thr);
    if (m == 2'd0) return x;
    p = xs * (g + 1);
    mag = (p < 0) ? -p : p;
    if (mag <= t) begin
      r = p;
    end else begin
      clipped = 1'b1;
      if (m == 2'd2) begin
        lim = t + ((mag - t) >> 2);
        if (lim > 32767) lim = 32767;
      end else begin
        lim = t;
      end
      r = (p < 0) ? -lim : lim;
    end
    return r[15:0];
  endfunction

  // Drives one cycle of inputs and runs the scoreboard on that cycle's
  // handshakes, observed shortly after the falling edge.
  task automatic applyStimulus(input bit inV, input logic [15:0] data, input logic [2:0] g,
                               input logic [1:0] m, input logic [15:0] thr, input bit outR);
    sbEntry_t e;
    bit clp;
    @(negedge CLK);
    in_valid    = inV;
    input_frame = data;
    gain        = g;
    mode        = m;
    threshold   = thr;
    out_ready   = outR;
    #1;
    if (out_valid && out_ready) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_out", 32'(output_frame), 32'hFFFF_FFFF);
      end else begin
        e = sbQ.pop_front();
        checkOutput("out_frame", 32'(output_frame), 32'(e.data));
        if (checkLat) checkOutput("latency", 32'(cycle - e.acceptCycle), 32'd3);
        if (e.clipped && modelClips < 65535) modelClips++;
      end
    end
    if (in_valid && in_ready) begin
      if (int'(g) > modelGain) modelGain++;
      else if (int'(g) < modelGain) modelGain--;
      e.data = modelOut(data, modelGain, m, thr, clp);
      e.clipped = clp;
      e.acceptCycle = cycle;
      sbQ.push_back(e);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sbQ.size() != 0; i++) begin
      applyStimulus(1'b0, 16'h0000, gain, mode, threshold, 1'b1);
    end
    checkOutput("sb_empty", 32'(sbQ.size()), 32'd0);
`ifdef OVERDRIVE_CLIP_STATS_EN
    checkOutput("clip_cnt", 32'(clip_cnt), 32'(modelClips));
`endif
  endtask

  task automatic doReset();
    @(negedge CLK);
    RESET_N   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    checkOutput("in_ready_rst", 32'(in_ready), 32'd0);
    sbQ.delete();
    modelGain  = 0;
    modelClips = 0;
    @(negedge CLK);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_frame", 32'(output_frame), 32'd0);
`ifdef OVERDRIVE_CLIP_STATS_EN
    checkOutput("rst_clip_cnt", 32'(clip_cnt), 32'd0);
`endif
    RESET_N = 1'b1;
  endtask

  initial begin
    logic [15:0] heldFrame;
    bit prevStall;
    logic [15:0] rThr;

    RESET_N     = 1'b0;
    in_valid    = 1'b0;
    input_frame = '0;
    gain        = '0;
    mode        = 2'd1;
    threshold   = 16'h4000;
    out_ready   = 1'b1;
    doReset();

    // Pass-through in HARD with latency measurement.
    checkLat = 1'b1;
    applyStimulus(1'b1, 16'h0000, 3'd1, 2'd1, 16'h4000, 1'b1);
    applyStimulus(1'b1, 16'h13A8, 3'd1, 2'd1, 16'h4000, 1'b1);
    drain();

    // Hard clip both polarities, then soft knee and soft saturation.
    applyStimulus(1'b1, 16'h7918, 3'd1, 2'd1, 16'h4000, 1'b1);
    applyStimulus(1'b1, 16'h86E8, 3'd1, 2'd1, 16'h4000, 1'b1);
    applyStimulus(1'b1, 16'h7918, 3'd1, 2'd2, 16'h4000, 1'b1);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 16'h7FFF, 3'd7, 2'd2, 16'h4000, 1'b1);
    drain();

    // Boundaries: T=0, threshold MSB, negative full scale, reserved mode.
    applyStimulus(1'b1, 16'h1234, 3'd7, 2'd1, 16'h0000, 1'b1);
    applyStimulus(1'b1, 16'hF000, 3'd7, 2'd2, 16'h0000, 1'b1);
    applyStimulus(1'b1, 16'h0000, 3'd7, 2'd2, 16'h0000, 1'b1);
    applyStimulus(1'b1, 16'h8000, 3'd7, 2'd1, 16'h8000, 1'b1);
    applyStimulus(1'b1, 16'h8000, 3'd7, 2'd2, 16'hFFFF, 1'b1);
    applyStimulus(1'b1, 16'h7918, 3'd1, 2'd3, 16'h4000, 1'b1);
    applyStimulus(1'b1, 16'h8000, 3'd7, 2'd0, 16'h0000, 1'b1);
    drain();

    // Gain ramp from reset toward code 7.
    doReset();
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 16'h0100, 3'd7, 2'd1, 16'h7FFF, 1'b1);
    drain();

    // Backpressure: five stalled cycles with input held valid.
    checkLat = 1'b0;
    prevStall = 1'b0;
    heldFrame = '0;
    for (int i = 0; i < 14; i++) begin
      applyStimulus(1'b1, 16'(16'h0500 + 16'(i * 16'h0333)), 3'(i % 8), 2'd2, 16'h3000, !(i >= 4 && i < 9));
      if (!out_ready && out_valid) begin
        checkOutput("in_ready_stall", 32'(in_ready), 32'd0);
        if (prevStall) checkOutput("hold_frame", 32'(output_frame), 32'(heldFrame));
        heldFrame = output_frame;
        prevStall = 1'b1;
      end else begin
        prevStall = 1'b0;
      end
    end
    drain();

    // Reset with three samples in flight, then bypass of negative full scale.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'h7000, 3'd6, 2'd1, 16'h1000, 1'b1);
    doReset();
    checkLat = 1'b1;
    applyStimulus(1'b1, 16'h8000, 3'd5, 2'd0, 16'h4000, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 16'h0000, 3'd5, 2'd0, 16'h4000, 1'b1);
    drain();

    // Random traffic with random backpressure and config changes.
    checkLat = 1'b0;
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 3))
        0:       rThr = 16'h0000;
        1:       rThr = 16'(16'h8000 | 16'($urandom()));
        default: rThr = 16'(16'($urandom()) & 16'h7FFF);
      endcase
      applyStimulus(($urandom_range(0, 3) != 0), 16'($urandom()), 3'($urandom_range(0, 7)),
                    2'($urandom_range(0, 3)), rThr, ($urandom_range(0, 3) != 0));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
